// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback types: register-file write command and the writeback source tag.
package writeback_arbiter_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WAIT_W     = 4;

  typedef logic [REG_ADDR_W-1:0] rv_reg_t;

  typedef struct packed {
    logic            enable;
    rv_reg_t         which_register;
    logic [XLEN-1:0] value;
  } reg_write_control_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2
  } wb_source_t;

endpackage

// File: rtl/writeback_arbiter_grant_logic.sv
// Combinational grant for the shared write port: loads first, ALU forced through after
// ALU_MAX_WAIT refusals unless both target the same live register.
module wb_grant_logic
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned ALU_MAX_WAIT = 4
) (
  input  logic              i_alu_valid,
  input  logic              i_alu_rd_en,
  input  rv_reg_t           i_alu_rd,
  input  logic              i_mem_valid,
  input  logic              i_mem_rd_en,
  input  rv_reg_t           i_mem_rd,
  input  logic [WAIT_W-1:0] i_wait_cnt,
  output wb_source_t        o_grant,
  output logic              o_alu_ready,
  output logic              o_mem_ready
);

  logic w_same_rd;
  logic w_starved;

  // Same live destination: the older load must land first, so no override.
  assign w_same_rd = i_alu_rd_en && i_mem_rd_en &&
                     (i_alu_rd == i_mem_rd) && (i_alu_rd != '0);
  assign w_starved = (i_wait_cnt == WAIT_W'(ALU_MAX_WAIT)) && !w_same_rd;

  always_comb begin
    o_grant = WB_NONE;
    if (i_alu_valid && i_mem_valid) begin
      o_grant = w_starved ? WB_ALU : WB_MEM;
    end else if (i_alu_valid) begin
      o_grant = WB_ALU;
    end else if (i_mem_valid) begin
      o_grant = WB_MEM;
    end
  end

  assign o_alu_ready = (o_grant == WB_ALU);
  assign o_mem_ready = (o_grant == WB_MEM);

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the register file's single write port between the ALU and load writeback paths,
// producing one registered write command per cycle.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned ALU_MAX_WAIT = 4,
  parameter int unsigned STAT_WIDTH   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  reg_write_control_t    alu_write,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  reg_write_control_t    mem_write,
  output logic                  mem_ready,
  output reg_write_control_t    write_control,
  output logic                  alu_stalled,
  output logic [STAT_WIDTH-1:0] conflict_count
);

  wb_source_t              w_grant;
  logic                    w_alu_grant;
  logic                    w_mem_grant;
  reg_write_control_t      w_sel;
  reg_write_control_t      w_next_write;
  logic [WAIT_W-1:0]       r_wait_cnt;
  reg_write_control_t      r_write_control;
  logic                    r_alu_stalled;
  logic [STAT_WIDTH-1:0]   r_conflict_count;

  wb_grant_logic #(
    .ALU_MAX_WAIT (ALU_MAX_WAIT)
  ) u_grant (
    .i_alu_valid (alu_valid),
    .i_alu_rd_en (alu_write.enable),
    .i_alu_rd    (alu_write.which_register),
    .i_mem_valid (mem_valid),
    .i_mem_rd_en (mem_write.enable),
    .i_mem_rd    (mem_write.which_register),
    .i_wait_cnt  (r_wait_cnt),
    .o_grant     (w_grant),
    .o_alu_ready (w_alu_grant),
    .o_mem_ready (w_mem_grant)
  );

  // Nothing is accepted while reset is held, so an in-flight request is simply dropped.
  assign alu_ready = w_alu_grant && !reset;
  assign mem_ready = w_mem_grant && !reset;

  // Next write command; x0 and disabled payloads are consumed but never written.
  always_comb begin
    w_sel        = (w_grant == WB_ALU) ? alu_write : mem_write;
    w_next_write = r_write_control;
    w_next_write.enable = 1'b0;
    if (alu_ready || mem_ready) begin
      w_next_write        = w_sel;
      w_next_write.enable = w_sel.enable && (w_sel.which_register != '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_write_control <= '0;
    end else begin
      r_write_control <= w_next_write;
    end
  end

  // Consecutive refusals of the current ALU request, saturating at the override point.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (!alu_valid || alu_ready) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != WAIT_W'(ALU_MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_alu_stalled    <= 1'b0;
      r_conflict_count <= '0;
    end else begin
      r_alu_stalled <= alu_valid && !alu_ready;
      if (alu_valid && mem_valid && (r_conflict_count != '1)) begin
        r_conflict_count <= r_conflict_count + STAT_WIDTH'(1);
      end
    end
  end

  assign write_control  = r_write_control;
  assign alu_stalled    = r_alu_stalled;
  assign conflict_count = r_conflict_count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int unsigned MAXW = 4;
  localparam int unsigned SW   = 4;
  localparam int          CONF_MAX = (1 << SW) - 1;

  logic               clock = 1'b0;
  logic               reset;
  logic               alu_valid;
  reg_write_control_t alu_write;
  logic               alu_ready;
  logic               mem_valid;
  reg_write_control_t mem_write;
  logic               mem_ready;
  reg_write_control_t write_control;
  logic               alu_stalled;
  logic [SW-1:0]      conflict_count;

  always #5 clock = ~clock;

  writeback_arbiter #(
    .ALU_MAX_WAIT (MAXW),
    .STAT_WIDTH   (SW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_write      (alu_write),
    .alu_ready      (alu_ready),
    .mem_valid      (mem_valid),
    .mem_write      (mem_write),
    .mem_ready      (mem_ready),
    .write_control  (write_control),
    .alu_stalled    (alu_stalled),
    .conflict_count (conflict_count)
  );

  int total = 0;
  int bad   = 0;

  reg_write_control_t m_wc;
  logic               m_stall;
  int                 m_conf;
  int                 m_refused;
  logic               acc_alu, acc_mem;
  logic               last_ar, last_mr;
  rv_reg_t            rd_pool [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wc      = '0;
    m_stall   = 1'b0;
    m_conf    = 0;
    m_refused = 0;
    acc_alu   = 1'b0;
    acc_mem   = 1'b0;
  endtask

  // One cycle: check readys against the rules, advance the model, check registered outputs.
  task automatic step();
    int                 g;
    logic               same;
    reg_write_control_t pay;
    #2;
    same = alu_write.enable && mem_write.enable &&
           (alu_write.which_register == mem_write.which_register) &&
           (alu_write.which_register != 0);
    if (alu_valid && mem_valid) g = (m_refused >= MAXW && !same) ? 1 : 2;
    else if (alu_valid)         g = 1;
    else if (mem_valid)         g = 2;
    else                        g = 0;
    last_ar = alu_ready;
    last_mr = mem_ready;
    chk("alu_ready", alu_ready, g == 1);
    chk("mem_ready", mem_ready, g == 2);
    acc_alu = (g == 1);
    acc_mem = (g == 2);
    if (g != 0) begin
      pay  = (g == 1) ? alu_write : mem_write;
      m_wc = pay;
      m_wc.enable = pay.enable && (pay.which_register != 0);
    end else begin
      m_wc.enable = 1'b0;
    end
    m_stall = alu_valid && (g != 1);
    if (alu_valid && mem_valid && m_conf < CONF_MAX) m_conf++;
    if (alu_valid && g != 1) m_refused = (m_refused < MAXW) ? m_refused + 1 : m_refused;
    else                     m_refused = 0;
    @(posedge clock);
    #1;
    chk("write_control", write_control, m_wc);
    chk("alu_stalled", alu_stalled, m_stall);
    chk("conflict_count", conflict_count, m_conf);
  endtask

  function automatic reg_write_control_t rand_pay();
    reg_write_control_t p;
    p.enable         = ($urandom_range(0, 7) != 0);
    p.which_register = rd_pool[$urandom_range(0, 4)];
    p.value          = $urandom;
    return p;
  endfunction

  initial begin
    rd_pool[0] = 5'd0;  rd_pool[1] = 5'd3;  rd_pool[2] = 5'd12;
    rd_pool[3] = 5'd17; rd_pool[4] = 5'd31;
    reset = 1'b1;
    alu_valid = 1'b1; mem_valid = 1'b1;
    alu_write = '0;   mem_write = '0;
    model_reset();
    #12;
    chk("rst_wc", write_control, 0);
    chk("rst_stall", alu_stalled, 0);
    chk("rst_conf", conflict_count, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;

    // Single ALU source.
    alu_valid = 1'b1; alu_write = '{1'b1, 5'd5, 32'h1234};
    step();
    chk("single_ready", last_ar, 1);
    chk("single_wc", write_control, {1'b1, 5'd5, 32'h1234});
    alu_valid = 1'b0;
    step();
    chk("single_idle_en", write_control.enable, 0);

    // Loads win while both are valid.
    alu_valid = 1'b1; alu_write = '{1'b1, 5'd3, 32'hA3};
    mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_write = '{1'b1, 5'd7, 32'(100 + i)};
      step();
      chk("prio_alu_refused", last_ar, 0);
      chk("prio_mem_accepted", last_mr, 1);
    end
    chk("prio_conf", conflict_count, 3);
    mem_valid = 1'b0;
    step();
    chk("prio_alu_after", last_ar, 1);
    chk("prio_alu_rd", write_control.which_register, 3);
    alu_valid = 1'b0;

    // x0 load is consumed but not written.
    mem_valid = 1'b1; mem_write = '{1'b1, 5'd0, 32'hFFFF_FFFF};
    step();
    chk("x0_ready", last_mr, 1);
    chk("x0_enable", write_control.enable, 0);

    // Starvation override after MAXW refusals.
    alu_valid = 1'b1; alu_write = '{1'b1, 5'd4, 32'hA4};
    mem_write = '{1'b1, 5'd9, 32'h99};
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 4) begin
        chk("starve_refused", last_ar, 0);
        chk("starve_stalled", alu_stalled, 1);
      end else begin
        chk("starve_forced", last_ar, 1);
        chk("starve_wc", write_control, {1'b1, 5'd4, 32'hA4});
      end
    end
    alu_write = '{1'b1, 5'd4, 32'hB4};
    step();
    chk("starve_cnt_cleared", last_ar, 0);
    mem_valid = 1'b0;
    step();
    chk("starve_restart_acc", last_ar, 1);
    alu_valid = 1'b0;

    // Same destination: no override, load lands first.
    alu_valid = 1'b1; alu_write = '{1'b1, 5'd12, 32'hAAAA};
    mem_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_write = '{1'b1, 5'd12, 32'(32'h5000 + i)};
      step();
      chk("samerd_alu_refused", last_ar, 0);
      chk("samerd_mem_value", write_control.value, 32'h5000 + i);
    end
    mem_valid = 1'b0;
    step();
    chk("samerd_alu_last", last_ar, 1);
    chk("samerd_alu_value", write_control.value, 32'hAAAA);
    chk("conf_saturated", conflict_count, CONF_MAX);
    alu_valid = 1'b0;
    step();

    // Random traffic honouring the hold-until-accepted rule.
    for (int c = 0; c < 1500; c++) begin
      if (!alu_valid || acc_alu) begin
        alu_valid = ($urandom_range(0, 9) < 6);
        alu_write = rand_pay();
      end
      if (!mem_valid || acc_mem) begin
        mem_valid = ($urandom_range(0, 9) < 6);
        mem_write = rand_pay();
      end
      step();
    end

    // Asynchronous reset in the middle of a cycle with a live write.
    alu_valid = 1'b1; alu_write = '{1'b1, 5'd6, 32'h66};
    mem_valid = 1'b1; mem_write = '{1'b1, 5'd8, 32'h88};
    step();
    chk("pre_rst_en", write_control.enable, 1);
    chk("pre_rst_stall", alu_stalled, 1);
    #3 reset = 1'b1;
    #1;
    chk("arst_wc", write_control, 0);
    chk("arst_stall", alu_stalled, 0);
    chk("arst_conf", conflict_count, 0);
    chk("arst_alu_ready", alu_ready, 0);
    chk("arst_mem_ready", mem_ready, 0);
    model_reset();
    @(posedge clock); #1;
    chk("arst_hold_wc", write_control, 0);
    #2;
    reset = 1'b0;
    alu_valid = 1'b1; alu_write = '{1'b1, 5'd6, 32'h67};
    mem_valid = 1'b0;
    step();
    chk("post_rst_wc", write_control, {1'b1, 5'd6, 32'h67});
    alu_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
